// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - multi-source reset synchroniser with ordered channel release
// Requests hold every channel in reset; channels then release low-to-high with fixed spacing.
module reset_sequencer #(
  parameter int                     NUM_SOURCES     = 2,
  parameter int                     NUM_CHANNELS    = 4,
  parameter int                     SYNC_STAGES     = 2,
  parameter logic [NUM_SOURCES-1:0] IN_POLARITY     = '0,
  parameter logic                   OUTPUT_POLARITY = 1'b1,
  parameter int                     MIN_ASSERT      = 8,
  parameter int                     RELEASE_DELAY   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n_i,
  input  logic [NUM_SOURCES-1:0]  async_reset_i,
  input  logic                    soft_reset_i,
  output logic [NUM_CHANNELS-1:0] sync_reset_o,
  output logic                    all_released_o
);

  localparam int CNT_MAX = (MIN_ASSERT > RELEASE_DELAY) ? MIN_ASSERT : RELEASE_DELAY;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

  logic [NUM_SOURCES-1:0]  sync_q [SYNC_STAGES];
  logic [NUM_SOURCES-1:0]  src_act;
  logic                    req;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  // bit k set means channel k has been released
  logic [NUM_CHANNELS-1:0] rel_q, rel_d;

  assign src_act = ~(sync_q[SYNC_STAGES-1] ^ IN_POLARITY);
  assign req     = (|src_act) | soft_reset_i;

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= ~IN_POLARITY;
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rel_q   <= '0;
    end else begin
      sync_q[0] <= async_reset_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rel_d   = rel_q;
    // a request overrides any count or release due on the same edge
    if (req) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rel_d   = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == CW'(MIN_ASSERT - 1)) begin
            rel_d   = NUM_CHANNELS'(1);
            cnt_d   = '0;
            idx_d   = '0;
            state_d = (NUM_CHANNELS == 1) ? RUN : RELEASE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == CW'(RELEASE_DELAY - 1)) begin
            rel_d = NUM_CHANNELS'({rel_q, 1'b1});
            idx_d = idx_q + IW'(1);
            cnt_d = '0;
            if (int'(idx_q) + 1 == NUM_CHANNELS - 1) state_d = RUN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RUN: ;
        default: state_d = HOLD;
      endcase
    end
  end

  assign sync_reset_o   = {NUM_CHANNELS{OUTPUT_POLARITY}} ^ rel_q;
  assign all_released_o = (state_q == RUN);

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed checks of reset_sequencer release ordering and request priority
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] async_reset;
  logic       soft_reset;
  logic [3:0] sync_reset;
  logic       all_released;

  logic       reset6_n;
  logic [1:0] async6;
  logic       soft6;
  logic [0:0] sync6;
  logic       all6;

  int checks = 0;
  int errors = 0;

  reset_sequencer dut (
    .clk            (clk),
    .reset_n_i      (reset_n),
    .async_reset_i  (async_reset),
    .soft_reset_i   (soft_reset),
    .sync_reset_o   (sync_reset),
    .all_released_o (all_released)
  );

  reset_sequencer #(
    .NUM_CHANNELS (1),
    .MIN_ASSERT   (1),
    .IN_POLARITY  (2'b11)
  ) dut6 (
    .clk            (clk),
    .reset_n_i      (reset6_n),
    .async_reset_i  (async6),
    .soft_reset_i   (soft6),
    .sync_reset_o   (sync6),
    .all_released_o (all6)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // expected outputs k edges after the reference, ch0 releasing at edge r0
  function automatic logic [3:0] seq_exp(input int k, input int r0);
    int n;
    if (k < r0) return 4'b1111;
    n = 1 + (k - r0) / 4;
    if (n >= 4) return 4'b0000;
    return 4'b1111 << n;
  endfunction

  task automatic run_seq(input int r0, input string tag);
    for (int k = 1; k <= r0 + 13; k++) begin
      tick(1);
      check($sformatf("%s_out@%0d", tag, k), 32'(sync_reset), 32'(seq_exp(k, r0)));
      check($sformatf("%s_all@%0d", tag, k), 32'(all_released), 32'(k >= r0 + 12));
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    async_reset = 2'b11;
    soft_reset  = 1'b0;
    reset6_n    = 1'b0;
    async6      = 2'b00;
    soft6       = 1'b0;

    // 1: power-on sequence
    tick(3);
    check("rst_out", 32'(sync_reset), 32'hF);
    check("rst_all", 32'(all_released), 32'h0);
    reset_n = 1'b1;
    run_seq(8, "t1");

    // 2: async pulse on source 0 while running
    async_reset = 2'b10;
    tick(1);
    check("t2_e1", 32'(sync_reset), 32'h0);
    tick(1);
    check("t2_e2", 32'(sync_reset), 32'h0);
    tick(1);
    check("t2_e3", 32'(sync_reset), 32'hF);
    check("t2_e3_all", 32'(all_released), 32'h0);
    async_reset = 2'b11;
    run_seq(10, "t2");

    // 3: soft request after ch1 released
    soft_reset = 1'b1;
    tick(1);
    soft_reset = 1'b0;
    tick(12);
    check("t3_1100", 32'(sync_reset), 32'hC);
    soft_reset = 1'b1;
    tick(1);
    check("t3_soft", 32'(sync_reset), 32'hF);
    soft_reset = 1'b0;
    run_seq(8, "t3");

    // 5: soft request on the same edge as the ch1 release
    soft_reset = 1'b1;
    tick(1);
    soft_reset = 1'b0;
    tick(11);
    check("t5_pre", 32'(sync_reset), 32'hE);
    soft_reset = 1'b1;
    tick(1);
    check("t5_coinc", 32'(sync_reset), 32'hF);
    check("t5_all", 32'(all_released), 32'h0);
    soft_reset = 1'b0;
    run_seq(8, "t5");

    // 4: block reset mid-release with source 1 held active
    soft_reset = 1'b1;
    tick(1);
    soft_reset = 1'b0;
    tick(10);
    check("t4_pre", 32'(sync_reset), 32'hE);
    reset_n     = 1'b0;
    async_reset = 2'b01;
    tick(1);
    check("t4_rst", 32'(sync_reset), 32'hF);
    check("t4_rst_all", 32'(all_released), 32'h0);
    reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      check($sformatf("t4_held@%0d", k), 32'(sync_reset), 32'hF);
    end
    async_reset = 2'b11;
    run_seq(10, "t4");

    // 6: single channel, MIN_ASSERT=1, active-high sources
    tick(1);
    check("t6_rst", 32'(sync6), 32'h1);
    check("t6_rst_all", 32'(all6), 32'h0);
    reset6_n = 1'b1;
    tick(1);
    check("t6_rel", 32'(sync6), 32'h0);
    check("t6_rel_all", 32'(all6), 32'h1);
    async6 = 2'b01;
    tick(2);
    check("t6_d2", 32'(sync6), 32'h0);
    tick(1);
    check("t6_d3", 32'(sync6), 32'h1);
    check("t6_d3_all", 32'(all6), 32'h0);
    async6 = 2'b00;
    tick(2);
    check("t6_r2", 32'(sync6), 32'h1);
    tick(1);
    check("t6_r3", 32'(sync6), 32'h0);
    check("t6_r3_all", 32'(all6), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
